// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and FSM encoding for the UART receive framer.
// Holds the 3-bit state encoding, the default bit period and the data width.
package uart_pkg;

    // 100 MHz system clock at 115200 baud
    localparam int DEF_CLKS_PER_BIT = 868;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        ARM    = 3'd0,
        IDLE   = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } state_t;

    // Even parity: the parity bit equals the XOR of the data bits
    function automatic logic even_parity(
        input logic [DATA_BITS-1:0] d
    );
        return ^d;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: bit-period divider for the UART receiver.
// Ports: clk, reset (sync, active-low), restart (zero the divider),
//        half_tick (ccnt at mid-bit), full_tick (ccnt at end of bit period).
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic half_tick,
    output logic full_tick
);

    localparam int W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [W-1:0] HALF = W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [W-1:0] FULL = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] r_ccnt;

    // Free-running modulo-CLKS_PER_BIT counter; the FSM re-phases it
    // through restart whenever a new alignment point is found.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ccnt <= '0;
        end else if (restart || full_tick) begin
            r_ccnt <= '0;
        end else begin
            r_ccnt <= r_ccnt + 1'b1;
        end
    end

    assign half_tick = (r_ccnt == HALF);
    assign full_tick = (r_ccnt == FULL);

endmodule

// File: rtl/uart_rx_framer.sv
// uart_rx_framer: UART receiver with line sync, mid-bit sampling,
// start/stop checks and a one-byte holding register with overrun flag.
// Ports: clk, reset (sync, active-low), rxd (async serial in),
//        rx_data/rx_valid/rx_ready (byte handshake),
//        frame_err/overrun (sticky), err_clr (clear pulse),
//        parity_err (sticky, only with UART_RX_PARITY_EN: 8E1 framing).
// Without UART_RX_PARITY_EN the framing is 8N1.
module uart_rx_framer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    input  logic                 err_clr
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [3:0]             r_bcnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   r_data;
    logic                   r_valid;
    logic                   r_ferr;
    logic                   r_ovr;
`ifdef UART_RX_PARITY_EN
    logic                   r_perr;
`endif

    logic w_rxs;
    logic w_half;
    logic w_full;
    logic w_restart;
    logic w_accept;

    // Synchroniser resets to the idle level so a reset does not itself
    // look like a falling edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rxd};
        end
    end

    assign w_rxs = r_sync[SYNC_STAGES-1];

    // ARM/IDLE: a low line re-phases the divider, so in ARM full_tick
    // only fires after CLKS_PER_BIT consecutive high cycles, and in
    // IDLE the start bit is timed from its falling edge.
    // START: the centre of the start bit becomes the data bit phase.
    assign w_restart = ((r_state == ARM || r_state == IDLE) && !w_rxs)
                     || (r_state == START && w_half);

    assign w_accept = r_valid && rx_ready;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .restart  (w_restart),
        .half_tick(w_half),
        .full_tick(w_full)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ARM;
            r_bcnt  <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr  <= 1'b0;
`endif
        end else begin
            // Clears come first so that a same-cycle error event below
            // overrides them.
            if (err_clr) begin
                r_ferr <= 1'b0;
                r_ovr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                r_perr <= 1'b0;
`endif
            end

            if (w_accept) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                ARM: begin
                    if (w_rxs && w_full) begin
                        r_state <= IDLE;
                    end
                end

                IDLE: begin
                    if (!w_rxs) begin
                        r_state <= START;
                    end
                end

                START: begin
                    if (w_half) begin
                        if (w_rxs) begin
                            r_state <= IDLE;
                        end else begin
                            r_bcnt  <= '0;
                            r_state <= DATA;
                        end
                    end
                end

                DATA: begin
                    if (w_full) begin
                        r_shift[r_bcnt[2:0]] <= w_rxs;
                        r_bcnt <= r_bcnt + 4'd1;
                        if (r_bcnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= PARITY;
`else
                            r_state <= STOP;
`endif
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (w_full) begin
                        if (w_rxs != even_parity(r_shift)) begin
                            r_perr <= 1'b1;
                        end
                        r_state <= STOP;
                    end
                end
`endif

                STOP: begin
                    if (w_full) begin
                        if (w_rxs) begin
                            // A byte consumed this same cycle frees the
                            // holding register, so that is not overrun.
                            if (!r_valid || w_accept) begin
                                r_data  <= r_shift;
                                r_valid <= 1'b1;
                            end else begin
                                r_ovr <= 1'b1;
                            end
                            r_state <= IDLE;
                        end else begin
                            // Bad stop bit: we may be misaligned, so wait
                            // for a full idle bit before hunting again.
                            r_ferr  <= 1'b1;
                            r_state <= ARM;
                        end
                    end
                end

                default: begin
                    r_state <= ARM;
                end
            endcase
        end
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_ferr;
    assign overrun   = r_ovr;
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_perr;
`endif

endmodule

// File: tb/tb_uart_rx_framer.sv
// tb_uart_rx_framer: directed bench for uart_rx_framer with a byte
// scoreboard; CLKS_PER_BIT = 16, 10-unit clock period.
module tb_uart_rx_framer;
    import uart_pkg::*;

    localparam int CPB = 16;

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic       rxd      = 1'b0;
    logic       rx_ready = 1'b0;
    logic       err_clr  = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t_start = 0;
    int t_rise  = -1;
    logic prev_valid = 1'b0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_framer #(
        .CLKS_PER_BIT(CPB),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rxd      (rxd),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .err_clr  (err_clr)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic stopb,
                        input logic use_par, input logic par);
        rxd = 1'b0;
        t_start = cyc;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            tick(CPB);
        end
        if (use_par) begin
            rxd = par;
            tick(CPB);
        end
        rxd = stopb;
        tick(CPB);
        rxd = 1'b1;
    endtask

    // Monitor: every accepted byte is popped from the scoreboard.
    always @(negedge clk) begin
        if (rx_valid === 1'b1 && prev_valid !== 1'b1) t_rise = cyc;
        prev_valid = rx_valid;
        if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $error("FAIL unexpected_byte: observed %0h expected none",
                       rx_data);
            end else begin
                chk("rx_byte", 32'(rx_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        n_fail++;
        $display("FAIL timeout: observed %0d cycles expected finish", cyc);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with the line held low
        tick(3);
        chk("rst_data", 32'(rx_data), 32'h00);
        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_state", 32'(dut.r_state), 32'(ARM));
        reset = 1'b1;
        rx_ready = 1'b1;

        // Low line from power-up is not a start bit
        tick(100);
        chk("low_valid", 32'(rx_valid), 32'd0);
        chk("low_ferr", 32'(frame_err), 32'd0);
        chk("low_state", 32'(dut.r_state), 32'(ARM));
        rxd = 1'b1;
        tick(20);
        chk("arm_to_idle", 32'(dut.r_state), 32'(IDLE));
        tick(5);

        // 8'hA5 with consumer ready, latency check
        exp_q.push_back(8'hA5);
        t_rise = -1;
        send(8'hA5, 1'b1, 1'b0, 1'b0);
        chk("a5_latency",
            32'((t_rise - t_start >= 153) && (t_rise - t_start <= 157)),
            32'd1);
        chk("a5_ferr", 32'(frame_err), 32'd0);
        chk("a5_ovr", 32'(overrun), 32'd0);
        tick(3);
        chk("a5_drained", 32'(exp_q.size()), 32'd0);

        // Back-to-back with consumer stalled: second byte is dropped
        rx_ready = 1'b0;
        exp_q.push_back(8'h3C);
        send(8'h3C, 1'b1, 1'b0, 1'b0);
        send(8'hC3, 1'b1, 1'b0, 1'b0);
        tick(2);
        chk("ovr_data", 32'(rx_data), 32'h3C);
        chk("ovr_valid", 32'(rx_valid), 32'd1);
        chk("ovr_flag", 32'(overrun), 32'd1);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        tick(1);
        chk("ovr_valid_drop", 32'(rx_valid), 32'd0);
        chk("ovr_drained", 32'(exp_q.size()), 32'd0);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("ovr_clr", 32'(overrun), 32'd0);
        rx_ready = 1'b1;

        // Stop bit forced low
        send(8'h55, 1'b0, 1'b0, 1'b0);
        tick(1);
        chk("fe_flag", 32'(frame_err), 32'd1);
        chk("fe_valid", 32'(rx_valid), 32'd0);
        chk("fe_state", 32'(dut.r_state), 32'(ARM));
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("fe_clr", 32'(frame_err), 32'd0);
        tick(20);
        chk("fe_rearm", 32'(dut.r_state), 32'(IDLE));
        exp_q.push_back(8'h01);
        send(8'h01, 1'b1, 1'b0, 1'b0);
        tick(3);
        chk("fe_next_byte", 32'(exp_q.size()), 32'd0);
        chk("fe_next_ferr", 32'(frame_err), 32'd0);

        // Short start-bit glitch
        tick(5);
        rxd = 1'b0;
        tick(4);
        rxd = 1'b1;
        tick(30);
        chk("gl_state", 32'(dut.r_state), 32'(IDLE));
        chk("gl_valid", 32'(rx_valid), 32'd0);
        chk("gl_ferr", 32'(frame_err), 32'd0);

        // Back-to-back frames, consumer always ready
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        send(8'h12, 1'b1, 1'b0, 1'b0);
        send(8'h34, 1'b1, 1'b0, 1'b0);
        tick(3);
        chk("b2b_drained", 32'(exp_q.size()), 32'd0);
        chk("b2b_ovr", 32'(overrun), 32'd0);

`ifdef UART_RX_PARITY_EN
        // 8E1: good and bad parity, byte delivered either way
        exp_q.push_back(8'h07);
        send(8'h07, 1'b1, 1'b1, 1'b1);
        tick(3);
        chk("par_ok_flag", 32'(parity_err), 32'd0);
        exp_q.push_back(8'h07);
        send(8'h07, 1'b1, 1'b1, 1'b0);
        tick(3);
        chk("par_bad_flag", 32'(parity_err), 32'd1);
        chk("par_drained", 32'(exp_q.size()), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_framer.md
# uart_rx_framer

Receives serial bytes on the board UART input and presents each one as a parallel byte with a valid/ready handshake.
- Sits directly upstream of the miner core inside `Wrapper`: it feeds the header/nonce loader that consumes work sent from the host.
- Handles input synchronisation, mid-bit sampling, start/stop validation, and a one-byte holding register with overrun detection.

## Interface
- `CLKS_PER_BIT`, 868: system clocks per UART bit (100 MHz / 115200 baud).
- `SYNC_STAGES`, 2: flops in the `rxd` synchroniser, minimum 2.
- `clk` input 1: system clock, rising edge.
- `reset` input 1: synchronous, active-low; the block is reset on any `clk` edge where `reset == 0`.
- `rxd` input 1: asynchronous serial line, idles high.
- `rx_data` output 8: received byte, LSB first on the wire.
- `rx_valid` output 1: `rx_data` holds an unconsumed byte.
- `rx_ready` input 1: consumer accepts the byte when `rx_valid & rx_ready`.
- `frame_err` output 1: sticky; stop bit sampled low.
- `overrun` output 1: sticky; a byte completed while `rx_valid` was still high.
- `err_clr` input 1: single-cycle pulse that clears `frame_err`, `overrun` and `parity_err`.
- `parity_err` output 1: sticky. Present only under `UART_RX_PARITY_EN`.

## Operation
- The synchronised line is `rxs`, taken from the last synchroniser stage. The bit counter `bcnt` is 4 bits wide. The clock divider `ccnt` is sized as $clog2(CLKS_PER_BIT).
- ARM state (entered on reset):
  - The block waits for `rxs` to stay high for `CLKS_PER_BIT` consecutive cycles, then goes to IDLE.
  - A low `rxd` held from power-up is therefore never taken as a start bit.
- IDLE: a falling level (`rxs == 0`) loads `ccnt = 0` and moves to START.
- START:
  - At `ccnt == CLKS_PER_BIT/2 - 1`, `rxs` is sampled.
  - If `rxs` is high (glitch), return to IDLE with no output and no error.
  - If `rxs` is low, set `ccnt = 0` and `bcnt = 0`, then go to DATA.
- DATA:
  - Each time `ccnt == CLKS_PER_BIT - 1`, `rxs` is shifted into bit `bcnt` of the shift register (LSB first), `bcnt` increments and `ccnt` wraps to 0.
  - After bit 7, go to PARITY if the macro is defined, otherwise to STOP.
- PARITY: one bit time. The sampled bit must equal the XOR of the 8 data bits (even parity); a mismatch sets `parity_err`.
- STOP: one bit time, sampled at the bit centre.
  - If `rxs == 1`: the byte is delivered. This happens even when the parity check failed.
  - If `rxs == 0`: set `frame_err`, discard the byte, and go to ARM, which forces line-idle resynchronisation.
  - On success, go to IDLE in the same cycle as the sample.
- Byte delivery:
  - If `rx_valid == 0`, load `rx_data` and set `rx_valid`.
  - If `rx_valid == 1` and the consumer is not accepting in that same cycle, keep the old `rx_data`, set `overrun` and drop the new byte.
  - If the consumer accepts in the same cycle as delivery, this is not an overrun: the new byte loads and `rx_valid` stays 1.
- Handshake: `rx_valid` falls the cycle after `rx_valid & rx_ready`, unless a new byte lands in that same cycle. `rx_data` is stable while `rx_valid` is high.
- Errors: a `err_clr` pulse in the same cycle as a new error event leaves the flag set (set wins).
- Reset mid-frame: the partial byte is discarded, all state goes to ARM and all outputs return to reset values. No byte is produced until the line is idle again.

## Timing
- Reset values: `rx_data = 8'h00`, `rx_valid = 0`, `frame_err = 0`, `overrun = 0`, `parity_err = 0`. State is ARM and all counters are 0.
- Input latency: `SYNC_STAGES` cycles from a pin change to `rxs`.
- Output latency:
  - `rx_valid` rises 1 cycle after the stop-bit centre sample.
  - That is about 9.5 bit times + `SYNC_STAGES` + 1 cycles after the falling edge of the start bit, plus one extra bit time when parity is enabled.
- Back-to-back frames: a start bit that begins right after the stop-bit centre is accepted, because IDLE is entered before the stop bit ends.
- Sustained throughput: 1 byte per 10 bit times (11 with parity).

## Configuration
- `UART_RX_PARITY_EN`:
  - Defined: 8E1 framing. The PARITY state and the `parity_err` port exist.
  - Undefined: 8N1 framing. No PARITY state and no `parity_err` port. `err_clr` affects only `frame_err` and `overrun`.

## Structure
- Package `uart_pkg` holds:
  - the state encoding constants ARM/IDLE/START/DATA/PARITY/STOP (3 bits);
  - the default `CLKS_PER_BIT`;
  - `DATA_BITS = 8`.
- One sub-module, `uart_bit_timer`: holds `ccnt` and outputs `half_tick` and `full_tick`, with a `restart` input. The FSM, shift register, holding register and flags stay in `uart_rx_framer`.

## Test plan
All runs use `CLKS_PER_BIT = 16`, `clk` period 10 ns, and start from `reset = 0` for 3 cycles.
- Line held low after reset for 100 cycles, then released high → no `rx_valid` and no `frame_err`. After 16 high cycles the block reaches IDLE.
- Send 8'hA5 (8N1) with `rx_ready = 1` → one `rx_valid` pulse with `rx_data = 8'hA5`, about 154 cycles after the start edge. No error flags.
- Send 8'h3C then 8'hC3 back-to-back with `rx_ready = 0` → `rx_data` stays 8'h3C, `overrun = 1`. Then one `rx_ready` cycle → `rx_valid` drops to 0.
- Send 8'h55 with the stop bit forced low → `frame_err = 1`, `rx_valid = 0`, block in ARM. Then `err_clr` → flag clears, and a following 8'h01 is received correctly.
- Start-bit glitch of 4 cycles low → block returns to IDLE with no byte and no error.
- With `UART_RX_PARITY_EN`: 8'h07 with a correct even-parity bit (1) → `rx_valid` with 8'h07. The same byte with parity 0 → `parity_err = 1` and the byte is still delivered.
